imem_fetch_responder: RTL

- Instruction-memory responder: the memory side of the fetch request interface (fetch, extend, fetch_src, pc). Returns instructions or vector targets to fetch logic.
- Backing store is 16-bit halfword memory of depth 2**ADDR_W, loaded through a side port. Models access latency with WAIT_CYCLES stall cycles per halfword.
- Reads one halfword for a normal instruction. Reads two halfwords for an extended instruction or any vector lookup (reset, interrupt, exception).

---
 rtl/imem_fetch_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: serves fetch requests from a halfword store,
// returning one or two halfwords after WAIT_CYCLES stall cycles per halfword.
module imem_fetch_responder #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned RST_VEC     = 0,
   parameter int unsigned INT_VEC     = 2,
   parameter int unsigned EXC_VEC     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch,
   input  logic              extend,
   input  logic [1:0]        fetch_src,
   input  logic [31:0]       pc,
   output logic [31:0]       instr,
   output logic              instr_valid,
   output logic              is_vector,
   output logic              busy,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [15:0]       ld_data
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                two_q, two_d;
   logic                is_vec_q, is_vec_d;
   logic [31:0]         instr_q, instr_d;
   logic                instr_valid_q, instr_valid_d;
   logic                is_vector_q, is_vector_d;

   logic [15:0]         mem_q [DEPTH];
   logic [ADDR_W-1:0]   rd_addr_c;
   logic [15:0]         rd_data_c;
   logic                pc_unused_c;

   // Load port; nonblocking write keeps same-edge captures read-before-write
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem_q[ld_addr] <= ld_data;
      end
   end

   // Second halfword wraps naturally through the ADDR_W-bit add
   assign rd_addr_c   = (state_q == LO) ? base_q + ADDR_W'(1) : base_q;
   assign rd_data_c   = mem_q[rd_addr_c];
   assign pc_unused_c = ^pc[31:ADDR_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         base_q        <= '0;
         two_q         <= 1'b0;
         is_vec_q      <= 1'b0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         is_vector_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         base_q        <= base_d;
         two_q         <= two_d;
         is_vec_q      <= is_vec_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         is_vector_q   <= is_vector_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      base_d        = base_q;
      two_d         = two_q;
      is_vec_d      = is_vec_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      is_vector_d   = is_vector_q;

      case (state_q)
         IDLE: begin
            if (fetch) begin
               unique case (fetch_src)
                  2'b00:   base_d = pc[ADDR_W-1:0];
                  2'b01:   base_d = ADDR_W'(INT_VEC);
                  2'b10:   base_d = ADDR_W'(EXC_VEC);
                  default: base_d = ADDR_W'(RST_VEC);
               endcase
               two_d    = extend | (fetch_src != 2'b00);
               is_vec_d = (fetch_src != 2'b00);
               cnt_d    = CNT_W'(WAIT_CYCLES);
               state_d  = HI;
            end
         end
         HI: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               instr_d[31:16] = rd_data_c;
               if (two_q) begin
                  cnt_d   = CNT_W'(WAIT_CYCLES);
                  state_d = LO;
               end else begin
                  instr_d[15:0] = 16'h0000;
                  instr_valid_d = 1'b1;
                  is_vector_d   = is_vec_q;
                  state_d       = IDLE;
               end
            end
         end
         LO: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               instr_d[15:0] = rd_data_c;
               instr_valid_d = 1'b1;
               is_vector_d   = is_vec_q;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign is_vector   = is_vector_q;
   assign busy        = (state_q != IDLE);

endmodule
